chameleon2_io_serout_n: RTL

//  Parametrised driver for a chain of 74HC595-style serial-out registers (ser_out_clk/dat/rclk).
//  It generalises the fixed LED/PS2/reset shift register on the Chameleon v2 to N bits and a

---
 rtl/chameleon2_io_pkg.sv | 23 ++
 rtl/chameleon2_serout_tick.sv | 30 +++
 rtl/chameleon2_io_serout_n.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/chameleon2_io_pkg.sv
// chameleon2_io_pkg: state encodings and width helper shared by the
// serial-out driver and its phase counter.
package chameleon2_io_pkg;

    typedef enum logic [2:0] {
        SO_IDLE     = 3'd0,
        SO_SHIFT_LO = 3'd1,
        SO_SHIFT_HI = 3'd2,
        SO_LATCH_HI = 3'd3,
        SO_LATCH_LO = 3'd4
    } so_state_t;

    // ceil(log2(v)), never below 1 so every counter keeps a bit
    function automatic int CLOG2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/chameleon2_serout_tick.sv
// chameleon2_serout_tick: CLK_DIV phase counter; phase_end marks the
// last clk cycle of every shift/latch phase.
module chameleon2_serout_tick
    import chameleon2_io_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic phase_end
);

    localparam int DW = CLOG2(CLK_DIV + 1);
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] cnt;

    assign phase_end = (cnt == LAST);

    // restart aligns cycle 0 of a frame with the start of a phase
    always_ff @(posedge clk) begin
        if (reset || restart || phase_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DW'(1);
        end
    end

endmodule

// File: rtl/chameleon2_io_serout_n.sv
// chameleon2_io_serout_n: N-bit 74HC595 chain driver with refresh.
// Optional SEROUT_READBACK_EN adds serial readback (ser_in_dat/q_out).
module chameleon2_io_serout_n
    import chameleon2_io_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int CLK_DIV        = 4,
    parameter int MSB_FIRST      = 1,
    parameter int REFRESH_CYCLES = 65535
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_in,
    input  logic             force_update,
`ifdef SEROUT_READBACK_EN
    input  logic             ser_in_dat,
    output logic [WIDTH-1:0] q_out,
    output logic             q_valid,
`endif
    output logic             busy,
    output logic             ser_out_clk,
    output logic             ser_out_dat,
    output logic             ser_out_rclk
);

    localparam int IW = CLOG2(WIDTH + 1);
    localparam int RW = CLOG2(REFRESH_CYCLES + 1);
    localparam logic [IW-1:0] LAST_BIT = IW'(WIDTH - 1);
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYCLES - 1);

    so_state_t        state, state_n;
    logic [IW-1:0]    idx, idx_n;
    logic [WIDTH-1:0] shadow, shadow_n;
    logic [WIDTH-1:0] last_sent, last_n;
    logic             pending, pending_n;
    logic [RW-1:0]    ref_cnt, ref_n;
    logic             busy_n, sclk_n, dat_n, rclk_n;
    logic             phase_end, start, ref_hit;

    function automatic logic first_bit(input logic [WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(
        input logic [WIDTH-1:0] v
    );
        return (MSB_FIRST != 0) ? (v << 1) : (v >> 1);
    endfunction

    assign ref_hit = (REFRESH_CYCLES != 0) && (ref_cnt == REF_LAST);
    assign start   = (state == SO_IDLE) &&
                     (pending || force_update ||
                      (d_in != last_sent) || ref_hit);

    chameleon2_serout_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk       (clk),
        .reset     (reset),
        .restart   (start),
        .phase_end (phase_end)
    );

    // next-state, shadow shifting and output decode
    always_comb begin
        state_n   = state;
        idx_n     = idx;
        shadow_n  = shadow;
        last_n    = last_sent;
        pending_n = pending;
        ref_n     = ref_cnt;
        busy_n    = busy;
        sclk_n    = ser_out_clk;
        dat_n     = ser_out_dat;
        rclk_n    = ser_out_rclk;
        if (state != SO_IDLE &&
            (force_update || d_in != last_sent)) begin
            pending_n = 1'b1;
        end
        unique case (state)
            SO_IDLE: begin
                if (start) begin
                    state_n   = SO_SHIFT_LO;
                    idx_n     = '0;
                    shadow_n  = d_in;
                    last_n    = d_in;
                    pending_n = 1'b0;
                    ref_n     = '0;
                    busy_n    = 1'b1;
                    sclk_n    = 1'b0;
                    dat_n     = first_bit(d_in);
                end else if (ref_cnt != '1) begin
                    ref_n = ref_cnt + RW'(1);
                end
            end
            SO_SHIFT_LO: begin
                if (phase_end) begin
                    state_n = SO_SHIFT_HI;
                    sclk_n  = 1'b1;
                end
            end
            SO_SHIFT_HI: begin
                if (phase_end) begin
                    sclk_n = 1'b0;
                    if (idx == LAST_BIT) begin
                        state_n = SO_LATCH_HI;
                        rclk_n  = 1'b1;
                    end else begin
                        state_n  = SO_SHIFT_LO;
                        idx_n    = idx + IW'(1);
                        shadow_n = advance(shadow);
                        dat_n    = first_bit(advance(shadow));
                    end
                end
            end
            SO_LATCH_HI: begin
                if (phase_end) begin
                    state_n = SO_LATCH_LO;
                    rclk_n  = 1'b0;
                end
            end
            SO_LATCH_LO: begin
                if (phase_end) begin
                    state_n = SO_IDLE;
                    busy_n  = 1'b0;
                end
            end
            default: begin
                state_n = SO_IDLE;
                busy_n  = 1'b0;
                sclk_n  = 1'b0;
                rclk_n  = 1'b0;
            end
        endcase
    end

    // state register and registered pin outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= SO_IDLE;
            idx          <= '0;
            shadow       <= '0;
            last_sent    <= '0;
            pending      <= 1'b1;
            ref_cnt      <= '0;
            busy         <= 1'b0;
            ser_out_clk  <= 1'b0;
            ser_out_dat  <= 1'b0;
            ser_out_rclk <= 1'b0;
        end else begin
            state        <= state_n;
            idx          <= idx_n;
            shadow       <= shadow_n;
            last_sent    <= last_n;
            pending      <= pending_n;
            ref_cnt      <= ref_n;
            busy         <= busy_n;
            ser_out_clk  <= sclk_n;
            ser_out_dat  <= dat_n;
            ser_out_rclk <= rclk_n;
        end
    end

`ifdef SEROUT_READBACK_EN
    logic [WIDTH-1:0] rb;
    logic             rise_now, latch_now;

    assign rise_now  = (state == SO_SHIFT_LO) && phase_end;
    assign latch_now = (state == SO_SHIFT_HI) && phase_end &&
                       (idx == LAST_BIT);

    // sample the chain tail as ser_out_clk rises; publish at latch
    always_ff @(posedge clk) begin
        if (reset) begin
            rb      <= '0;
            q_out   <= '0;
            q_valid <= 1'b0;
        end else begin
            q_valid <= latch_now;
            if (rise_now) begin
                rb <= (MSB_FIRST != 0) ?
                      ((rb << 1) | WIDTH'(ser_in_dat)) :
                      ((rb >> 1) |
                       (WIDTH'(ser_in_dat) << (WIDTH - 1)));
            end
            if (latch_now) q_out <= rb;
        end
    end
`endif

endmodule
